// File: rtl/pacman_input_ctrl.sv
// Pac-Man input conditioning: PS/2 + joystick merge and coin pulse shaping.
// Optional autofire on joyN[9] is built when INPUT_AUTOFIRE_EN is defined.
module pacman_input_ctrl #(
  parameter int PULSE_CYC    = 2400000,
  parameter int GAP_CYC      = 2400000,
  parameter int MAX_PEND     = 3,
  parameter int AUTOFIRE_CYC = 1200000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  output logic [3:0]  p1_dir,
  output logic [3:0]  p2_dir,
  output logic        p1_fire,
  output logic        p2_fire,
  output logic        start1,
  output logic        start2,
  output logic        cheat,
  output logic        coin_pulse,
  output logic [1:0]  coin_pend
);

  localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [1:0] PMAX = 2'(MAX_PEND);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_st_e;

  logic        armed_q, tog_q, ev;
  logic [18:0] key_q, key_d, hit;
  logic [3:0]  p1_dir_q, p2_dir_q;
  logic        p1_fire_q, p2_fire_q;
  logic        start1_q, start2_q, cheat_q;
  logic        raw_q, raw2_q, req, dec;
  logic        f1_src, f2_src, f1, f2;
  coin_st_e    st_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  pend_q;
  logic        pulse_q;

  assign ev = armed_q & (ps2_key[10] != tog_q);

  // Arrows accept the E0 prefix; everything else must be a plain code.
  always_comb begin
    hit = '0;
    case (ps2_key[7:0])
      8'h75: hit[3] = 1'b1;
      8'h72: hit[2] = 1'b1;
      8'h6B: hit[1] = 1'b1;
      8'h74: hit[0] = 1'b1;
      default: ;
    endcase
    if (!ps2_key[8]) begin
      case (ps2_key[7:0])
        8'h29: hit[4]  = 1'b1;
        8'h14: hit[5]  = 1'b1;
        8'h05: hit[6]  = 1'b1;
        8'h16: hit[7]  = 1'b1;
        8'h06: hit[8]  = 1'b1;
        8'h1E: hit[9]  = 1'b1;
        8'h04: hit[10] = 1'b1;
        8'h2E: hit[11] = 1'b1;
        8'h36: hit[12] = 1'b1;
        8'h0C: hit[13] = 1'b1;
        8'h2D: hit[17] = 1'b1;
        8'h2B: hit[16] = 1'b1;
        8'h23: hit[15] = 1'b1;
        8'h34: hit[14] = 1'b1;
        8'h1C: hit[18] = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    key_d = key_q;
    if (ev) key_d = ps2_key[9] ? (key_q | hit) : (key_q & ~hit);
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      armed_q <= 1'b0;
      tog_q   <= 1'b0;
      key_q   <= '0;
    end else begin
      armed_q <= 1'b1;
      tog_q   <= ps2_key[10];
      key_q   <= key_d;
    end
  end

  assign f1_src = key_q[4] | key_q[5] | joy1[4];
  assign f2_src = key_q[18] | joy2[4];

`ifdef INPUT_AUTOFIRE_EN
  localparam int AW = $clog2(AUTOFIRE_CYC + 1);
  logic          af_q;
  logic [AW-1:0] af_cnt_q;
  logic          unused_joy;
  assign unused_joy = ^{joy1[15:10], joy2[15:10]};

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      af_q     <= 1'b1;
      af_cnt_q <= '0;
    end else if (af_cnt_q == AW'(AUTOFIRE_CYC - 1)) begin
      af_q     <= ~af_q;
      af_cnt_q <= '0;
    end else begin
      af_cnt_q <= af_cnt_q + AW'(1);
    end
  end

  assign f1 = joy1[9] ? (f1_src & af_q) : f1_src;
  assign f2 = joy2[9] ? (f2_src & af_q) : f2_src;
`else
  logic unused_joy;
  assign unused_joy = ^{joy1[15:9], joy2[15:9]};
  assign f1 = f1_src;
  assign f2 = f2_src;
`endif

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      p1_dir_q  <= '0;
      p2_dir_q  <= '0;
      p1_fire_q <= 1'b0;
      p2_fire_q <= 1'b0;
      start1_q  <= 1'b0;
      start2_q  <= 1'b0;
      cheat_q   <= 1'b0;
      raw_q     <= 1'b0;
      raw2_q    <= 1'b0;
    end else begin
      p1_dir_q  <= key_q[3:0] | joy1[3:0];
      p2_dir_q  <= key_q[17:14] | joy2[3:0];
      p1_fire_q <= f1;
      p2_fire_q <= f2;
      start1_q  <= key_q[6] | key_q[7] | joy1[5] | joy2[5];
      start2_q  <= key_q[8] | key_q[9] | joy1[6] | joy2[6];
      cheat_q   <= key_q[13] | joy1[8] | joy2[8];
      raw_q     <= |key_q[12:10] | joy1[7] | joy2[7];
      raw2_q    <= raw_q;
    end
  end

  assign req = raw_q & ~raw2_q;
  assign dec = (st_q == IDLE) && (pend_q != 2'd0);

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      case ({req, dec})
        2'b10:   if (pend_q != PMAX) pend_q <= pend_q + 2'd1;
        2'b01:   pend_q <= pend_q - 2'd1;
        default: ;
      endcase
      case (st_q)
        IDLE: if (pend_q != 2'd0) begin
          st_q    <= PULSE;
          cnt_q   <= CW'(PULSE_CYC - 1);
          pulse_q <= 1'b1;
        end
        PULSE: if (cnt_q == '0) begin
          st_q    <= GAP;
          cnt_q   <= CW'(GAP_CYC - 1);
          pulse_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
        GAP: if (cnt_q == '0) st_q <= IDLE;
             else cnt_q <= cnt_q - CW'(1);
        default: st_q <= IDLE;
      endcase
    end
  end

  assign p1_dir     = p1_dir_q;
  assign p2_dir     = p2_dir_q;
  assign p1_fire    = p1_fire_q;
  assign p2_fire    = p2_fire_q;
  assign start1     = start1_q;
  assign start2     = start2_q;
  assign cheat      = cheat_q;
  assign coin_pulse = pulse_q;
  assign coin_pend  = pend_q;

endmodule
